// File: rtl/data_sram_confreg_pkg.sv
// data_sram_confreg_pkg: shared confreg constants and the byte-lane merge helper
package data_sram_confreg_pkg;
  localparam logic [15:0] CONF_BASE_HI = 16'hBFAF;
  localparam logic [15:0] OFF_LED = 16'h0000;
  localparam logic [15:0] OFF_SWITCH = 16'h0004;
  localparam logic [15:0] OFF_TIMER = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH = 16'h000C;
  localparam logic [15:0] OFF_STORE_CNT = 16'h0010;
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] we);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = we[i] ? wdata[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/data_sram_confreg_confreg_regs.sv
// confreg_regs: MMIO register file, switch synchroniser, timer, store counter and read mux
module confreg_regs
  import data_sram_confreg_pkg::*;
#(
  parameter int SW_W = 8,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hit,
  input  logic [3:0]       we,
  input  logic [15:0]      off,
  input  logic [31:0]      wdata,
  input  logic             store_inc,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic [31:0]      rd
);
  logic [SW_W-1:0] sw1, sw2;
  logic [31:0] timer, scratch, store_cnt;
  logic wr;
  assign wr = hit & (|we);
  // register updates; a timer write replaces that cycle's increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw1 <= '0;
      sw2 <= '0;
      led <= '0;
      timer <= '0;
      scratch <= '0;
      store_cnt <= '0;
    end else begin
      sw1 <= switch;
      sw2 <= sw1;
      if (wr && off == OFF_LED) led <= LED_W'(lane_merge(32'(led), wdata, we));
      timer <= (wr && off == OFF_TIMER) ? lane_merge(timer, wdata, we) : timer + 32'd1;
      if (wr && off == OFF_SCRATCH) scratch <= lane_merge(scratch, wdata, we);
      if (store_inc) store_cnt <= store_cnt + 32'd1;
    end
  end
  // read mux over current register values; unmapped offsets read zero
  always_comb begin
    rd = off == OFF_LED       ? 32'(led) :
         off == OFF_SWITCH    ? 32'(sw2) :
         off == OFF_TIMER     ? timer :
         off == OFF_SCRATCH   ? scratch :
         off == OFF_STORE_CNT ? store_cnt : '0;
  end
endmodule

// File: rtl/data_sram_confreg.sv
// data_sram_confreg: data SRAM responder decoding to a block RAM or confreg MMIO
module data_sram_confreg
  import data_sram_confreg_pkg::*;
#(
  parameter int RAM_AW = 14,
  parameter logic [15:0] CONF_HI = CONF_BASE_HI,
  parameter int SW_W = 8,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led
);
  logic [31:0] mem [2**RAM_AW];
  logic [31:0] ram_q, conf_q, conf_rd;
  logic conf_hit, ram_hit, sel_conf, vld;
  logic [RAM_AW-1:0] idx;
  logic unused_addr;
  assign conf_hit = data_sram_en & (data_sram_addr[31:16] == CONF_HI);
  assign ram_hit = data_sram_en & ~conf_hit;
  assign idx = data_sram_addr[RAM_AW+1:2];
  assign unused_addr = ^data_sram_addr[1:0];
  confreg_regs #(.SW_W(SW_W), .LED_W(LED_W)) u_regs (
    .clk(clk),
    .resetn(resetn),
    .hit(conf_hit),
    .we(data_sram_we),
    .off(data_sram_addr[15:0]),
    .wdata(data_sram_wdata),
    .store_inc(ram_hit & (|data_sram_we)),
    .switch(switch),
    .led(led),
    .rd(conf_rd)
  );
  // read-first block RAM with per-byte write lanes, no reset on the array
  always_ff @(posedge clk) begin
    if (ram_hit) ram_q <= mem[idx];
    for (int i = 0; i < 4; i++)
      if (ram_hit && data_sram_we[i]) mem[idx][8*i+:8] <= data_sram_wdata[8*i+:8];
  end
  // remember which source answered the last access so rdata holds while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld <= 1'b0;
      sel_conf <= 1'b0;
      conf_q <= '0;
    end else if (data_sram_en) begin
      vld <= 1'b1;
      sel_conf <= conf_hit;
      if (conf_hit) conf_q <= conf_rd;
    end
  end
  assign data_sram_rdata = !vld ? '0 : sel_conf ? conf_q : ram_q;
endmodule

// File: tb/tb_data_sram_confreg.sv
// tb_data_sram_confreg: directed self-checking bench for data_sram_confreg
module tb_data_sram_confreg;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  logic [3:0] we = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [7:0] switch = '0;
  logic [15:0] led;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  data_sram_confreg dut (
    .clk(clk),
    .resetn(resetn),
    .data_sram_en(en),
    .data_sram_we(we),
    .data_sram_addr(addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .switch(switch),
    .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0;
    we = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    resetn = 1'b1;
    idle(10);
    acc(4'h0, 32'hBFAF0008, 0);
    chk("timer_cnt", rdata, 32'd10);
    acc(4'hF, 32'hBFAF0008, 32'hFFFFFFFE);
    acc(4'h0, 32'hBFAF0008, 0);
    chk("timer_fe", rdata, 32'hFFFFFFFE);
    acc(4'h0, 32'hBFAF0008, 0);
    chk("timer_ff", rdata, 32'hFFFFFFFF);
    acc(4'h0, 32'hBFAF0008, 0);
    chk("timer_wrap", rdata, 32'h0);
    acc(4'hF, 32'h100, 32'h11223344);
    acc(4'b0010, 32'h100, 32'h0000AA00);
    acc(4'h0, 32'h100, 0);
    chk("ram_merge", rdata, 32'h1122AA44);
    acc(4'h0, 32'hBFAF0010, 0);
    chk("store_cnt", rdata, 32'd2);
    acc(4'hF, 32'h200, 32'hDEADBEEF);
    acc(4'hF, 32'h200, 32'h0);
    chk("read_first", rdata, 32'hDEADBEEF);
    acc(4'h0, 32'h200, 0);
    chk("after_wr", rdata, 32'h0);
    acc(4'hF, 32'hBFAF0000, 32'hFFFF1234);
    chk("led_out", 32'(led), 32'h1234);
    acc(4'h0, 32'hBFAF0000, 0);
    chk("led_rd", rdata, 32'h00001234);
    switch = 8'hA5;
    acc(4'h0, 32'hBFAF0004, 0);
    chk("sw_old", rdata, 32'h0);
    idle(1);
    acc(4'h0, 32'hBFAF0004, 0);
    chk("sw_new", rdata, 32'h000000A5);
    acc(4'h0, 32'hBFAF0020, 0);
    chk("unmap_rd", rdata, 32'h0);
    acc(4'hF, 32'hBFAF0020, 32'hFFFFFFFF);
    acc(4'h0, 32'hBFAF0020, 0);
    chk("unmap_wr", rdata, 32'h0);
    acc(4'h0, 32'hBFAF000C, 0);
    chk("unmap_scr", rdata, 32'h0);
    acc(4'h0, 32'hBFAF0000, 0);
    chk("unmap_led", rdata, 32'h00001234);
    acc(4'h0, 32'h100, 0);
    idle(5);
    chk("hold", rdata, 32'h1122AA44);
    acc(4'hF, 32'hBFAF000C, 32'h12345678);
    acc(4'h0, 32'hBFAF000C, 0);
    chk("scratch", rdata, 32'h12345678);
    #3;
    resetn = 1'b0;
    #1;
    chk("ar_rdata", rdata, 32'h0);
    chk("ar_led", 32'(led), 32'h0);
    chk("ar_timer", dut.u_regs.timer, 32'h0);
    chk("ar_scratch", dut.u_regs.scratch, 32'h0);
    chk("ar_store", dut.u_regs.store_cnt, 32'h0);
    idle(1);
    resetn = 1'b1;
    acc(4'h0, 32'h100, 0);
    chk("ram_keep", rdata, 32'h1122AA44);
    acc(4'h0, 32'hBFAF000C, 0);
    chk("scr_clear", rdata, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
